// File: rtl/axi4lite_regbank_if.sv
// AXI4-Lite bus interface shared by the register bank and its masters.
// The clk/rst_n members exist for bus-level users; the register bank clocks from its own ports.
interface axi4lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic clk,
    input logic rst_n
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;
    logic                    rlast;

    modport master_mp (
        input  clk, rst_n,
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, rlast, output rready
    );

    modport slave_mp (
        input  clk, rst_n,
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, rlast, input rready
    );
endinterface

// File: rtl/axi4lite_regbank.sv
// AXI4-Lite slave register bank with flat register outputs and per-register write pulses.
// Define AXIL_REGBANK_HWSTAT_EN to make registers NUM_RW..NUM_REGS-1 read-only hw_status views.
module axi4lite_regbank #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int NUM_RW     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    axi4lite_if.slave_mp                   s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int unused_num_rw = NUM_RW;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  aw_full;
    logic                  w_full;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;
    logic                  bvalid;
    logic [1:0]            bresp;
    logic                  rvalid;
    logic [1:0]            rresp;
    logic [DATA_WIDTH-1:0] rdata;

    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  commit;
    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  rd_ok;
    logic                  unused;

    function automatic logic writable(input logic [ADDR_WIDTH-1:0] idx);
`ifdef AXIL_REGBANK_HWSTAT_EN
        return idx < ADDR_WIDTH'(NUM_RW);
`else
        return idx < ADDR_WIDTH'(NUM_REGS);
`endif
    endfunction

    assign wr_idx = aw_addr >> OFFS;
    assign rd_idx = s_axi.araddr >> OFFS;
    assign commit = aw_full && w_full && !bvalid;
    assign wr_ok  = writable(wr_idx);

    // Read mux samples the array as it stands in the AR handshake cycle.
    always_comb begin
        rd_val = '0;
        rd_ok  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == ADDR_WIDTH'(i)) begin
                rd_ok = 1'b1;
`ifdef AXIL_REGBANK_HWSTAT_EN
                if (i >= NUM_RW) rd_val = hw_status[i*DATA_WIDTH +: DATA_WIDTH];
                else             rd_val = regs[i];
`else
                rd_val = regs[i];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            reg_wr  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            reg_wr <= '0;
            if (s_axi.awvalid && !aw_full) begin
                aw_full <= 1'b1;
                aw_addr <= s_axi.awaddr;
            end
            if (s_axi.wvalid && !w_full) begin
                w_full <= 1'b1;
                w_data <= s_axi.wdata;
                w_strb <= s_axi.wstrb;
            end
            // Buffers can only be full here, so no handshake competes with the clear.
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_ok ? 2'b00 : 2'b10;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (wr_ok && wr_idx == ADDR_WIDTH'(i)) begin
                        reg_wr[i] <= 1'b1;
                        for (int b = 0; b < STRB_W; b++) begin
                            if (w_strb[b]) regs[i][b*8 +: 8] <= w_data[b*8 +: 8];
                        end
                    end
                end
            end else if (bvalid && s_axi.bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid <= 1'b0;
            rresp  <= 2'b00;
            rdata  <= '0;
        end else if (s_axi.arvalid && !rvalid) begin
            rvalid <= 1'b1;
            rdata  <= rd_val;
            rresp  <= rd_ok ? 2'b00 : 2'b10;
        end else if (rvalid && s_axi.rready) begin
            rvalid <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
`ifdef AXIL_REGBANK_HWSTAT_EN
        if (g >= NUM_RW) begin : g_ro
            assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = '0;
        end else begin : g_rw
            assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
        end
`else
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
`endif
    end

    assign s_axi.awready = !aw_full;
    assign s_axi.wready  = !w_full;
    assign s_axi.bvalid  = bvalid;
    assign s_axi.bresp   = bresp;
    assign s_axi.arready = !rvalid;
    assign s_axi.rvalid  = rvalid;
    assign s_axi.rresp   = rresp;
    assign s_axi.rdata   = rdata;
    assign s_axi.rlast   = 1'b1;

    assign unused = ^{s_axi.clk, s_axi.rst_n, s_axi.awprot, s_axi.arprot, hw_status};
endmodule

// File: tb/tb_axi4lite_regbank.sv
// Self-checking bench for axi4lite_regbank: directed timing scenarios plus random traffic
// against an array-based register model. Runs in both builds of AXIL_REGBANK_HWSTAT_EN.
module tb_axi4lite_regbank;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NR  = 16;
    localparam int NRW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_n;
    logic [NR*DW-1:0] reg_q;
    logic [NR-1:0]    reg_wr;
    logic [NR*DW-1:0] hw_status;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] model [NR];
    int pulse_cnt [NR];

    always #5 clk = ~clk;
    assign rst_n = ~rst;

    axi4lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus (.clk(clk), .rst_n(rst_n));

    axi4lite_regbank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RW(NRW)) dut (
        .clk(clk),
        .rst(rst),
        .s_axi(bus),
        .reg_q(reg_q),
        .reg_wr(reg_wr),
        .hw_status(hw_status)
    );

    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) if (reg_wr[i] === 1'b1) pulse_cnt[i]++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit m_writable(input int idx);
`ifdef AXIL_REGBANK_HWSTAT_EN
        return idx < NRW;
`else
        return idx < NR;
`endif
    endfunction

    function automatic logic [DW-1:0] m_read(input int idx);
        if (idx >= NR) return '0;
`ifdef AXIL_REGBANK_HWSTAT_EN
        if (idx >= NRW) return hw_status[idx*DW +: DW];
`endif
        return model[idx];
    endfunction

    function automatic logic [1:0] m_rresp(input int idx);
        return (idx < NR) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [1:0] m_bresp(input int idx);
        return m_writable(idx) ? 2'b00 : 2'b10;
    endfunction

    function automatic void m_write(input int idx, input logic [DW-1:0] d, input logic [3:0] s);
        if (!m_writable(idx)) return;
        for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < NR; i++) model[i] = '0;
    endfunction

    function automatic logic [NR*DW-1:0] m_regq();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_writable(i) ? model[i] : '0;
        return v;
    endfunction

    function automatic int pulse_total();
        int t = 0;
        for (int i = 0; i < NR; i++) t += pulse_cnt[i];
        return t;
    endfunction

    function automatic logic [AW-1:0] addr_of(input int idx);
        return (AW'(idx) << 2) | AW'($urandom_range(0, 3));
    endfunction

    // ---------------- bus helpers (no checking) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awaddr = '0; bus.awprot = '0; bus.wdata = '0; bus.wstrb = '0;
        bus.araddr = '0; bus.arprot = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        bit done, aw_hs, w_hs, b_hs;
        done = 1'b0;
        resp = 2'bxx;
        bus.awaddr = addr; bus.awprot = 3'($urandom); bus.awvalid = 1'b1;
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1; bus.bready = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            b_hs  = bus.bvalid && bus.bready;
            if (b_hs) resp = bus.bresp;
            step();
            if (aw_hs) bus.awvalid = 1'b0;
            if (w_hs)  bus.wvalid = 1'b0;
            if (b_hs)  done = 1'b1;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                           output logic [1:0] resp, output logic last);
        bit done, ar_hs, r_hs;
        done = 1'b0;
        data = 'x; resp = 2'bxx; last = 1'bx;
        bus.araddr = addr; bus.arprot = 3'($urandom); bus.arvalid = 1'b1; bus.rready = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            ar_hs = bus.arvalid && bus.arready;
            r_hs  = bus.rvalid && bus.rready;
            if (r_hs) begin data = bus.rdata; resp = bus.rresp; last = bus.rlast; end
            step();
            if (ar_hs) bus.arvalid = 1'b0;
            if (r_hs)  done = 1'b1;
        end
        bus.arvalid = 1'b0; bus.rready = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1; idle_bus(); step(); step();
        rst = 1'b0; m_clear(); step();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; idle_bus(); step(); step();
        tests++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111)
            begin fails++; $display("FAIL reset_ready: got %b want 111", {bus.awready, bus.wready, bus.arready}); end
        tests++; if ({bus.bvalid, bus.rvalid, bus.bresp, bus.rresp} !== 6'b0)
            begin fails++; $display("FAIL reset_resp: got %b want 0", {bus.bvalid, bus.rvalid, bus.bresp, bus.rresp}); end
        tests++; if (bus.rdata !== '0)
            begin fails++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
        tests++; if (reg_q !== '0 || reg_wr !== '0)
            begin fails++; $display("FAIL reset_regs: reg_q %h reg_wr %h want 0", reg_q, reg_wr); end
        rst = 1'b0; m_clear(); step();
    endtask

    task automatic test_write_read();
        logic [1:0] r; logic [DW-1:0] d; logic l; int p0, idx; logic [DW-1:0] wd; logic [3:0] ws;
        p0 = pulse_cnt[2];
        bus.awaddr = 32'h08; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        tests++; if ({bus.awready, bus.wready, bus.bvalid} !== 3'b000)
            begin fails++; $display("FAIL wr_t1: aw/w/b got %b want 000", {bus.awready, bus.wready, bus.bvalid}); end
        step();
        m_write(2, 32'hDEADBEEF, 4'hF);
        tests++; if ({bus.bvalid, bus.bresp} !== 3'b100)
            begin fails++; $display("FAIL wr_t2_b: bvalid/bresp got %b want 100", {bus.bvalid, bus.bresp}); end
        tests++; if (reg_q[2*DW +: DW] !== 32'hDEADBEEF || reg_wr !== 16'h0004)
            begin fails++; $display("FAIL wr_t2_reg: reg2 %h reg_wr %h want deadbeef 0004", reg_q[2*DW +: DW], reg_wr); end
        tests++; if ({bus.awready, bus.wready} !== 2'b11)
            begin fails++; $display("FAIL wr_t2_ready: got %b want 11", {bus.awready, bus.wready}); end
        bus.bready = 1'b1; step(); bus.bready = 1'b0;
        tests++; if (bus.bvalid !== 1'b0 || pulse_cnt[2] - p0 !== 1)
            begin fails++; $display("FAIL wr_b_done: bvalid %b pulses %0d want 0 1", bus.bvalid, pulse_cnt[2] - p0); end
        bus.araddr = 32'h08; bus.arvalid = 1'b1; bus.rready = 1'b0;
        step();
        bus.arvalid = 1'b0;
        tests++; if ({bus.rvalid, bus.arready, bus.rresp, bus.rlast} !== 5'b10001 || bus.rdata !== 32'hDEADBEEF)
            begin fails++; $display("FAIL rd_t1: flags %b rdata %h want 10001 deadbeef",
                {bus.rvalid, bus.arready, bus.rresp, bus.rlast}, bus.rdata); end
        bus.rready = 1'b1; step(); bus.rready = 1'b0;
        tests++; if ({bus.rvalid, bus.arready} !== 2'b01)
            begin fails++; $display("FAIL rd_t2: rvalid/arready got %b want 01", {bus.rvalid, bus.arready}); end
        for (int k = 0; k < 8; k++) begin
            idx = $urandom_range(0, NR - 1); wd = $urandom; ws = 4'($urandom);
            do_write(addr_of(idx), wd, ws, r);
            m_write(idx, wd, ws);
            tests++; if (r !== m_bresp(idx))
                begin fails++; $display("FAIL rand_bresp[%0d]: got %b want %b", idx, r, m_bresp(idx)); end
            do_read(addr_of(idx), d, r, l);
            tests++; if (d !== m_read(idx) || r !== 2'b00 || l !== 1'b1)
                begin fails++; $display("FAIL rand_rd[%0d]: got %h/%b/%b want %h/00/1", idx, d, r, l, m_read(idx)); end
        end
    endtask

    task automatic test_strobe_order();
        pulse_reset();
        bus.wdata = 32'h11223344; bus.wstrb = 4'b0101; bus.wvalid = 1'b1; bus.bready = 1'b0;
        step();
        bus.wvalid = 1'b0;
        tests++; if ({bus.wready, bus.awready} !== 2'b01)
            begin fails++; $display("FAIL so_wbuf: wready/awready got %b want 01", {bus.wready, bus.awready}); end
        step(); step();
        bus.awaddr = 32'h16; bus.awvalid = 1'b1;
        step();
        bus.awvalid = 1'b0;
        tests++; if (bus.bvalid !== 1'b0 || reg_q[5*DW +: DW] !== '0)
            begin fails++; $display("FAIL so_commit_cycle: bvalid %b reg5 %h want 0 0", bus.bvalid, reg_q[5*DW +: DW]); end
        step();
        m_write(5, 32'h11223344, 4'b0101);
        tests++; if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || reg_q[5*DW +: DW] !== 32'h00220044)
            begin fails++; $display("FAIL so_result: bvalid %b bresp %b reg5 %h want 1 00 00220044",
                bus.bvalid, bus.bresp, reg_q[5*DW +: DW]); end
        bus.bready = 1'b1; step(); bus.bready = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [1:0] r; logic [DW-1:0] d; logic l; int idx, p0; logic [AW-1:0] a;
        for (int k = 0; k < 4; k++) begin
            idx = (k == 0) ? 16 : $urandom_range(NR, 300);
            a = (k == 0) ? 32'h40 : addr_of(idx);
            p0 = pulse_total();
            do_write(a, $urandom, 4'hF, r);
            tests++; if (r !== 2'b10 || pulse_total() !== p0 || reg_q !== m_regq())
                begin fails++; $display("FAIL oor_wr[%h]: bresp %b pulses %0d reg_q changed=%b want 10 0 0",
                    a, r, pulse_total() - p0, reg_q !== m_regq()); end
            do_read(a, d, r, l);
            tests++; if (d !== '0 || r !== 2'b10)
                begin fails++; $display("FAIL oor_rd[%h]: got %h/%b want 0/10", a, d, r); end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] da, db; int p0; bit stable;
        da = $urandom; db = $urandom; p0 = pulse_cnt[6];
        bus.awaddr = addr_of(3); bus.wdata = da; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        step();
        m_write(3, da, 4'hF);
        tests++; if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00)
            begin fails++; $display("FAIL b2b_first: bvalid %b bresp %b want 1 00", bus.bvalid, bus.bresp); end
        bus.awaddr = addr_of(6); bus.wdata = db; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        tests++; if ({bus.awready, bus.wready, bus.bvalid} !== 3'b001)
            begin fails++; $display("FAIL b2b_buffered: aw/w/b got %b want 001", {bus.awready, bus.wready, bus.bvalid}); end
        stable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (bus.bvalid !== 1'b1 || reg_q[6*DW +: DW] !== model[6] || pulse_cnt[6] !== p0) stable = 1'b0;
        end
        tests++; if (!stable)
            begin fails++; $display("FAIL b2b_hold: early second commit, reg6 %h want %h", reg_q[6*DW +: DW], model[6]); end
        bus.bready = 1'b1;
        step();
        tests++; if (bus.bvalid !== 1'b0 || reg_q[6*DW +: DW] !== model[6])
            begin fails++; $display("FAIL b2b_gap: bvalid %b reg6 %h want 0 %h", bus.bvalid, reg_q[6*DW +: DW], model[6]); end
        step();
        m_write(6, db, 4'hF);
        tests++; if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || reg_q[6*DW +: DW] !== db)
            begin fails++; $display("FAIL b2b_second: bvalid %b bresp %b reg6 %h want 1 00 %h",
                bus.bvalid, bus.bresp, reg_q[6*DW +: DW], db); end
        step();
        bus.bready = 1'b0;
        tests++; if (bus.bvalid !== 1'b0 || pulse_cnt[6] - p0 !== 1)
            begin fails++; $display("FAIL b2b_end: bvalid %b pulses %0d want 0 1", bus.bvalid, pulse_cnt[6] - p0); end
    endtask

    task automatic test_collision();
        logic [DW-1:0] old_v, new_v; logic [1:0] r; logic [DW-1:0] d; logic l;
        old_v = model[4]; new_v = ~old_v;
        bus.awaddr = addr_of(4); bus.wdata = new_v; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = addr_of(4); bus.arvalid = 1'b1; bus.rready = 1'b0;
        step();
        bus.arvalid = 1'b0;
        m_write(4, new_v, 4'hF);
        tests++; if (bus.rvalid !== 1'b1 || bus.rdata !== old_v || reg_q[4*DW +: DW] !== new_v)
            begin fails++; $display("FAIL coll_same_edge: rdata %h reg4 %h want %h %h",
                bus.rdata, reg_q[4*DW +: DW], old_v, new_v); end
        bus.bready = 1'b1; bus.rready = 1'b1; step();
        bus.bready = 1'b0; bus.rready = 1'b0;
        do_read(addr_of(4), d, r, l);
        tests++; if (d !== new_v || r !== 2'b00)
            begin fails++; $display("FAIL coll_after: got %h/%b want %h/00", d, r, new_v); end
    endtask

    task automatic test_rready_stall();
        int idx; logic [DW-1:0] exp_d;
        idx = $urandom_range(0, NR - 1); exp_d = m_read(idx);
        bus.araddr = addr_of(idx); bus.arvalid = 1'b1; bus.rready = 1'b0;
        step();
        bus.arvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++; if (bus.rvalid !== 1'b1 || bus.arready !== 1'b0 || bus.rdata !== exp_d)
                begin fails++; $display("FAIL stall[%0d]: rvalid %b arready %b rdata %h want 1 0 %h",
                    k, bus.rvalid, bus.arready, bus.rdata, exp_d); end
            step();
        end
        bus.rready = 1'b1; step(); bus.rready = 1'b0;
        tests++; if ({bus.rvalid, bus.arready} !== 2'b01)
            begin fails++; $display("FAIL stall_release: rvalid/arready %b want 01", {bus.rvalid, bus.arready}); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] r; logic [DW-1:0] wd; bit seen;
        bus.awaddr = addr_of(7); bus.awvalid = 1'b1;
        bus.araddr = addr_of(1); bus.arvalid = 1'b1; bus.rready = 1'b0; bus.bready = 1'b0;
        step();
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        tests++; if (bus.awready !== 1'b0 || bus.rvalid !== 1'b1)
            begin fails++; $display("FAIL rm_pending: awready %b rvalid %b want 0 1", bus.awready, bus.rvalid); end
        rst = 1'b1;
        step();
        tests++; if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b11100 ||
                     bus.rdata !== '0 || reg_q !== '0 || reg_wr !== '0)
            begin fails++; $display("FAIL rm_outputs: flags %b rdata %h reg_q %h want 11100 0 0",
                {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, bus.rdata, reg_q); end
        rst = 1'b0; m_clear(); step();
        wd = $urandom;
        bus.wdata = wd; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        step();
        bus.wvalid = 1'b0;
        step(); step();
        tests++; if (bus.bvalid !== 1'b0)
            begin fails++; $display("FAIL rm_stale_aw: bvalid %b want 0", bus.bvalid); end
        bus.awaddr = addr_of(7); bus.awvalid = 1'b1; bus.bready = 1'b1;
        seen = 1'b0; r = 2'bxx;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (bus.bvalid === 1'b1) begin seen = 1'b1; r = bus.bresp; end
            step();
            bus.awvalid = 1'b0;
        end
        bus.bready = 1'b0;
        m_write(7, wd, 4'hF);
        tests++; if (r !== 2'b00 || reg_q[7*DW +: DW] !== wd)
            begin fails++; $display("FAIL rm_rewrite: bresp %b reg7 %h want 00 %h", r, reg_q[7*DW +: DW], wd); end
    endtask

    task automatic test_random();
        logic [1:0] r; logic [DW-1:0] d, wd; logic l; logic [3:0] ws; int idx, p0, okw;
        p0 = pulse_total(); okw = 0;
        for (int k = 0; k < 60; k++) begin
            idx = $urandom_range(0, NR + 1);
            if (($urandom & 1) != 0) begin
                wd = $urandom; ws = 4'($urandom);
                do_write(addr_of(idx), wd, ws, r);
                if (m_writable(idx)) okw++;
                m_write(idx, wd, ws);
                tests++; if (r !== m_bresp(idx))
                    begin fails++; $display("FAIL rnd_wr[%0d]: bresp %b want %b", idx, r, m_bresp(idx)); end
            end else begin
                do_read(addr_of(idx), d, r, l);
                tests++; if (d !== m_read(idx) || r !== m_rresp(idx))
                    begin fails++; $display("FAIL rnd_rd[%0d]: got %h/%b want %h/%b", idx, d, r, m_read(idx), m_rresp(idx)); end
            end
        end
        tests++; if (reg_q !== m_regq() || pulse_total() - p0 !== okw)
            begin fails++; $display("FAIL rnd_final: pulses %0d want %0d, reg_q match=%b",
                pulse_total() - p0, okw, reg_q === m_regq()); end
    endtask

`ifdef AXIL_REGBANK_HWSTAT_EN
    task automatic test_hwstat();
        logic [1:0] r; logic [DW-1:0] d; logic l; int p0;
        hw_status[12*DW +: DW] = 32'hCAFEF00D;
        do_read(32'h30, d, r, l);
        tests++; if (d !== 32'hCAFEF00D || r !== 2'b00)
            begin fails++; $display("FAIL hw_read: got %h/%b want cafef00d/00", d, r); end
        p0 = pulse_total();
        do_write(32'h30, 32'h12345678, 4'hF, r);
        tests++; if (r !== 2'b10 || pulse_total() !== p0 || reg_q[12*DW +: DW] !== '0)
            begin fails++; $display("FAIL hw_write: bresp %b pulses %0d reg12 %h want 10 0 0",
                r, pulse_total() - p0, reg_q[12*DW +: DW]); end
        do_read(32'h30, d, r, l);
        tests++; if (d !== 32'hCAFEF00D)
            begin fails++; $display("FAIL hw_reread: got %h want cafef00d", d); end
        hw_status[12*DW +: DW] = 32'h0BADC0DE;
        do_read(32'h30, d, r, l);
        tests++; if (d !== 32'h0BADC0DE)
            begin fails++; $display("FAIL hw_live: got %h want 0badc0de", d); end
    endtask
`endif

    initial begin
        idle_bus();
        for (int i = 0; i < NR; i++) hw_status[i*DW +: DW] = $urandom;
        m_clear();
        test_reset();
        test_write_read();
        test_strobe_order();
        test_out_of_range();
        test_back_to_back();
        test_collision();
        test_rready_stall();
        test_reset_mid();
        test_random();
`ifdef AXIL_REGBANK_HWSTAT_EN
        test_hwstat();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axi4lite_regbank.md
# axi4lite_regbank

AXI4-Lite slave that implements a bank of NUM_REGS memory-mapped control/status registers. It is the responder end of the `axi4lite_if` bus: a CPU or test master drives the `master_mp` side, and this block terminates the `slave_mp` side. Register contents go to the datapath as flat outputs, along with per-register write strobes.

## Interface
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, register/data width; legal values are 32 or 64.
- NUM_REGS, 16, number of registers; must be at least 2.
- NUM_RW, 8, index of the first read-only status register; used only with AXIL_REGBANK_HWSTAT_EN; must satisfy 1 ≤ NUM_RW < NUM_REGS.
- clk  in  1  the only clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- s_axi  slave_mp  axi4lite_if #(ADDR_WIDTH,DATA_WIDTH)  AXI4-Lite slave port; the interface's own clk/rst_n are not used.
- reg_q  out  NUM_REGS*DATA_WIDTH  register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- reg_wr  out  NUM_REGS  one-cycle pulse per register on a successful write commit.
- hw_status  in  NUM_REGS*DATA_WIDTH  status values for read-only registers; ignored unless the macro is defined.

## Operation
- Word index = awaddr/araddr >> log2(DATA_WIDTH/8). Low byte-offset bits are ignored.
- Index ≥ NUM_REGS is out of range.
  - A write to it changes nothing and returns bresp=2'b10 (SLVERR).
  - A read of it returns rdata=0 and rresp=2'b10.
- awprot and arprot are ignored.
- Write path:
  - There is a one-entry AW holding buffer and a one-entry W holding buffer.
  - awready = !aw_full and wready = !w_full, both driven from registers.
  - AW and W are accepted independently and in either order.
- Commit happens on the edge where aw_full && w_full && !bvalid.
  - For each byte lane with wstrb[b]=1, the byte is written into reg[idx].
  - reg_wr[idx] pulses on the commit edge, only for OKAY writes.
  - Both buffers clear and bvalid is set.
- bvalid is held until bready. It drops on the edge where bvalid && bready.
- Read path:
  - arready = !rvalid.
  - On an AR handshake, rdata/rresp/rvalid are registered.
  - rvalid is held with rdata stable until rready.
  - rlast is tied to 1.
- Only one read and one write are outstanding at a time. Read and write paths run concurrently.
- Read/write collision on the same register: the read samples the array in its AR handshake cycle. A commit on that same edge is not visible to that read.

## Timing
- Reset values:
  - awready=1, wready=1, arready=1.
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
  - reg_q=0, reg_wr=0.
  - Both holding buffers are empty.
- Write latency:
  - AW and W handshakes in the same cycle T: commit at the end of T+1; reg_q updated and bvalid=1 in T+2.
  - AW and W in different cycles: commit happens the cycle after the later handshake.
- awready/wready go low the cycle after their handshake and return high the cycle after commit.
- If bvalid is still pending, a second AW/W pair may be buffered, but it does not commit until the cycle after the B handshake.
- Read latency: AR handshake in T gives rvalid=1 in T+1. With rready=1, rvalid=0 and arready=1 in T+2. Peak rate is one read per 2 cycles.
- Reset mid-transaction drops all buffered and outstanding transactions and returns all outputs to their reset values on the next edge.

## Configuration
- AXIL_REGBANK_HWSTAT_EN
  - Defined:
    - Registers NUM_RW..NUM_REGS-1 are read-only.
    - Reads of them return the hw_status slice, sampled in the AR handshake cycle.
    - Writes to them change nothing, return SLVERR, and produce no reg_wr pulse.
    - Their reg_q slices are 0.
  - Undefined: all NUM_REGS registers are read/write, and hw_status is ignored.

## Test plan
- Write 0xDEADBEEF to addr 0x08 (AW and W in the same cycle, wstrb=4'hF), then read 0x08 → bresp=0 in T+2, reg_wr[2] pulses once, rdata=0xDEADBEEF, rresp=0, rlast=1.
- W issued 3 cycles before AW, wstrb=4'b0101, data 0x11223344 into a register holding 0 → register becomes 0x00220044, and bvalid rises the cycle after commit.
- Write to addr 0x40 and read addr 0x40 (NUM_REGS=16) → bresp=2'b10, rresp=2'b10, rdata=0, no reg_wr pulse, reg_q unchanged.
- bready held low for 5 cycles while a second write pair is issued → second AW/W accepted and buffered, no second commit until the cycle after the first B handshake, two OKAY responses in order.
- rready held low for 4 cycles → rdata stable and arready=0 throughout. Assert rst mid-write (AW buffered) → next cycle all outputs at reset values; a later write to the same address commits normally.
- With the macro defined and hw_status[idx 12]=0xCAFEF00D: read 0x30 → 0xCAFEF00D; write 0x30 → SLVERR, and the read value is unchanged.
